// File: rtl/video_linebuf_pkg.sv
// Shared types and per-scale lookups for the line-buffer fill engine.
package video_linebuf_pkg;

    localparam int LB_IDX_W    = 11;
    localparam int LB_BANK_BIT = 10;
    localparam int PIX_W       = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_UNPACK = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    // Source pixels per line: ceil(h_active / (pixel_width + 1)).
    function automatic logic [PIX_W-1:0] src_pixels(input logic [1:0] pw, input int h_active);
        int n;
        case (pw)
            2'd0:    n = h_active;
            2'd1:    n = (h_active + 1) / 2;
            2'd2:    n = (h_active + 2) / 3;
            default: n = (h_active + 3) / 4;
        endcase
        return PIX_W'(n);
    endfunction

    function automatic logic [PIX_W-1:0] words_per_row(input logic [1:0] pw, input int h_active);
        return PIX_W'((int'(src_pixels(pw, h_active)) + 3) / 4);
    endfunction

endpackage

// File: rtl/video_linebuf_rowgen.sv
// Source row address and vertical repeat sequencing for the line-buffer fill.
module video_linebuf_rowgen
    import video_linebuf_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [1:0]        pixel_height,
    input  logic              advance,
    input  logic [PIX_W-1:0]  words,
    output logic [ADDR_W-1:0] row_addr
);

    logic [1:0] rep_cnt;

    // A row is rendered pixel_height+1 times before moving on by one row of words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_addr <= '0;
            rep_cnt  <= '0;
        end else if (load) begin
            row_addr <= frame_base;
            rep_cnt  <= pixel_height;
        end else if (advance) begin
            if (rep_cnt == 2'd0) begin
                row_addr <= row_addr + ADDR_W'(words);
                rep_cnt  <= pixel_height;
            end else begin
                rep_cnt <= rep_cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/video_linebuf_fill.sv
// Fetches one source row from VRAM per line and unpacks it into the
// double-banked 8bpp line buffer, with horizontal and vertical scaling.
module video_linebuf_fill
    import video_linebuf_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int ADDR_W   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          pixel_width,
    input  logic [1:0]          pixel_height,
    input  logic [ADDR_W-1:0]   frame_base,
    input  logic                frame_start,
    input  logic                line_start,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_strobe,
    input  logic                bus_ack,
    input  logic [31:0]         bus_rdata,
    output logic [LB_IDX_W-1:0] linebuf_wr_idx,
    output logic [7:0]          linebuf_wr_data,
    output logic                linebuf_wr_en,
    output logic                linebuf_bank,
    output logic                busy,
    output logic                overrun,
    output state_t              dbg_state
);

    // Bus handshake: bus_strobe rises with a stable bus_addr and stays high
    // until the cycle bus_ack is seen; bus_rdata is taken in that same cycle.
    state_t             state;
    logic [1:0]         pw_lat;
    logic [PIX_W-1:0]   pix_cnt;
    logic [PIX_W-1:0]   word_cnt;
    logic [23:0]        word_q;
    logic [1:0]         left;
    logic               pend_frame;
    logic               pend_line;
    logic [ADDR_W-1:0]  row_addr;
    logic [PIX_W-1:0]   n_line;
    logic               ev;
    logic               act;
    logic               act_frame;
    logic               act_line;
    logic               emit;
    logic               line_done;

    assign n_line    = src_pixels(pw_lat, H_ACTIVE);
    assign ev        = line_start | frame_start;
    assign bus_addr  = row_addr + ADDR_W'(word_cnt);
    assign dbg_state = state;
    assign emit      = (state == S_UNPACK) && (left != 2'd0) && (pix_cnt < n_line);
    assign line_done = (state == S_UNPACK) && !ev && !emit && (pix_cnt >= n_line);

    // act: an event is taken now. A request still in flight is drained first,
    // so the row address never moves under an outstanding strobe.
    always_comb begin
        act       = 1'b0;
        act_frame = 1'b0;
        act_line  = 1'b0;
        case (state)
            S_IDLE:   act = ev;
            S_FETCH:  act = ev & bus_ack;
            S_UNPACK: act = ev;
            default:  act = bus_ack;
        endcase
        if (state == S_DRAIN && !ev) begin
            act_frame = act & pend_frame;
            act_line  = act & pend_line;
        end else begin
            act_frame = act & frame_start;
            act_line  = act & line_start;
        end
    end

    video_linebuf_rowgen #(.ADDR_W(ADDR_W)) u_rowgen (
        .clk          (clk),
        .rst          (rst),
        .load         (act_frame),
        .frame_base   (frame_base),
        .pixel_height (pixel_height),
        .advance      (line_done),
        .words        (words_per_row(pw_lat, H_ACTIVE)),
        .row_addr     (row_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            pw_lat          <= '0;
            pix_cnt         <= '0;
            word_cnt        <= '0;
            word_q          <= '0;
            left            <= '0;
            pend_frame      <= 1'b0;
            pend_line       <= 1'b0;
            bus_strobe      <= 1'b0;
            linebuf_wr_idx  <= '0;
            linebuf_wr_data <= '0;
            linebuf_wr_en   <= 1'b0;
            linebuf_bank    <= 1'b0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            linebuf_wr_en <= 1'b0;
            overrun       <= ev && (state != S_IDLE);
            if (act_line) begin
                state        <= S_FETCH;
                bus_strobe   <= 1'b1;
                busy         <= 1'b1;
                pw_lat       <= pixel_width;
                linebuf_bank <= ~linebuf_bank;
                pix_cnt      <= '0;
                word_cnt     <= '0;
                pend_frame   <= 1'b0;
                pend_line    <= 1'b0;
            end else if (act) begin
                state      <= S_IDLE;
                bus_strobe <= 1'b0;
                busy       <= 1'b0;
                pend_frame <= 1'b0;
                pend_line  <= 1'b0;
            end else begin
                case (state)
                    S_FETCH: begin
                        if (ev) begin
                            state      <= S_DRAIN;
                            pend_frame <= frame_start;
                            pend_line  <= line_start;
                        end else if (bus_ack) begin
                            bus_strobe      <= 1'b0;
                            word_q          <= bus_rdata[31:8];
                            word_cnt        <= word_cnt + 10'd1;
                            left            <= 2'd3;
                            linebuf_wr_en   <= 1'b1;
                            linebuf_wr_idx  <= {linebuf_bank, pix_cnt};
                            linebuf_wr_data <= bus_rdata[7:0];
                            pix_cnt         <= pix_cnt + 10'd1;
                            state           <= S_UNPACK;
                        end
                    end
                    S_UNPACK: begin
                        if (emit) begin
                            linebuf_wr_en   <= 1'b1;
                            linebuf_wr_idx  <= {linebuf_bank, pix_cnt};
                            linebuf_wr_data <= word_q[7:0];
                            word_q          <= {8'd0, word_q[23:8]};
                            left            <= left - 2'd1;
                            pix_cnt         <= pix_cnt + 10'd1;
                        end else if (pix_cnt < n_line) begin
                            state      <= S_FETCH;
                            bus_strobe <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        // Newest event wins; the in-flight word is thrown away on ack.
                        if (ev) begin
                            pend_frame <= frame_start;
                            pend_line  <= line_start;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_linebuf_fill.sv
// Self-checking bench for video_linebuf_fill: vector table, corner sequences, random lines.
module tb_video_linebuf_fill;
    import video_linebuf_pkg::*;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    pixel_width = '0;
    logic [1:0]    pixel_height = '0;
    logic [AW-1:0] frame_base = '0;
    logic          frame_start = 1'b0;
    logic          line_start = 1'b0;
    logic [AW-1:0] bus_addr;
    logic          bus_strobe;
    logic          bus_ack;
    logic [31:0]   bus_rdata;
    logic [10:0]   linebuf_wr_idx;
    logic [7:0]    linebuf_wr_data;
    logic          linebuf_wr_en;
    logic          linebuf_bank;
    logic          busy;
    logic          overrun;
    state_t        dbg_state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    video_linebuf_fill #(.H_ACTIVE(640), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_width     (pixel_width),
        .pixel_height    (pixel_height),
        .frame_base      (frame_base),
        .frame_start     (frame_start),
        .line_start      (line_start),
        .bus_addr        (bus_addr),
        .bus_strobe      (bus_strobe),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata),
        .linebuf_wr_idx  (linebuf_wr_idx),
        .linebuf_wr_data (linebuf_wr_data),
        .linebuf_wr_en   (linebuf_wr_en),
        .linebuf_bank    (linebuf_bank),
        .busy            (busy),
        .overrun         (overrun),
        .dbg_state       (dbg_state)
    );

    // VRAM responder: ack after ack_delay cycles of strobe, data derived from address.
    int          ack_delay = 0;
    logic [31:0] salt = '0;
    logic [2:0]  wait_cnt;

    function automatic logic [31:0] rd_of(input logic [AW-1:0] a, input logic [31:0] s);
        return ({17'd0, a} * 32'h04040404 + 32'h03020100) ^ s;
    endfunction

    assign bus_ack   = bus_strobe && (int'(wait_cnt) >= ack_delay);
    assign bus_rdata = rd_of(bus_addr, salt);

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= '0;
        else if (bus_strobe && !bus_ack) wait_cnt <= wait_cnt + 3'd1;
        else wait_cnt <= '0;
    end

    // Monitor: everything the DUT writes or fetches, plus overrun pulses.
    logic [18:0]   got_q[$];
    logic [AW-1:0] got_a_q[$];
    int            ov_cnt = 0;

    always @(negedge clk) begin
        if (linebuf_wr_en) got_q.push_back({linebuf_wr_idx, linebuf_wr_data});
        if (bus_strobe && bus_ack) got_a_q.push_back(bus_addr);
        if (overrun) ov_cnt++;
    end

    // Reference model state and expectations.
    logic [AW-1:0] m_row = '0;
    logic [1:0]    m_rep = '0;
    logic          m_bank = 1'b0;
    logic [18:0]   exp_q[$];
    logic [AW-1:0] exp_a_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int n_of(input logic [1:0] pw);
        return (640 + int'(pw)) / (int'(pw) + 1);
    endfunction

    function automatic int w_of(input logic [1:0] pw);
        return (n_of(pw) + 3) / 4;
    endfunction

    function automatic int busy_of(input logic [1:0] pw, input int d);
        int n, w;
        n = n_of(pw);
        w = w_of(pw);
        return (w - 1) * (5 + d) + d + 1 + (n - 4 * (w - 1));
    endfunction

    task automatic model_line(input bit do_frame, input logic [1:0] pw, input logic [1:0] ph,
                              input logic [AW-1:0] base);
        int            n, w;
        logic [31:0]   d;
        logic [AW-1:0] a;
        n = n_of(pw);
        w = w_of(pw);
        if (do_frame) begin
            m_row = base;
            m_rep = ph;
        end
        m_bank = ~m_bank;
        for (int j = 0; j < w; j++) exp_a_q.push_back(m_row + AW'(j));
        for (int i = 0; i < n; i++) begin
            a = m_row + AW'(i / 4);
            d = rd_of(a, salt);
            exp_q.push_back({m_bank, 10'(i), d[8 * (i % 4) +: 8]});
        end
        if (m_rep == 2'd0) begin
            m_row = m_row + AW'(w);
            m_rep = ph;
        end else begin
            m_rep = m_rep - 2'd1;
        end
    endtask

    task automatic score(input int wb, input int ab);
        check("wr_count", got_q.size() - wb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (wb + i < got_q.size()) check("wr_entry", got_q[wb + i], exp_q[i]);
        check("fetch_count", got_a_q.size() - ab, exp_a_q.size());
        for (int i = 0; i < exp_a_q.size(); i++)
            if (ab + i < got_a_q.size()) check("fetch_addr", got_a_q[ab + i], exp_a_q[i]);
        exp_q.delete();
        exp_a_q.delete();
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 4000) begin
            cyc++;
            @(negedge clk);
        end
        check("busy_timeout", busy, 0);
    endtask

    task automatic run_line(input bit do_frame, input logic [1:0] pw, input logic [1:0] ph,
                            input logic [AW-1:0] base, input int dly,
                            output int busy_cyc, output logic [AW-1:0] first_a,
                            output int nwr, output int nf, output logic [10:0] last_idx);
        int          wb, ab;
        logic [18:0] tmp;
        pixel_width  = pw;
        pixel_height = ph;
        frame_base   = base;
        ack_delay    = dly;
        model_line(do_frame, pw, ph, base);
        wb = got_q.size();
        ab = got_a_q.size();
        @(negedge clk);
        line_start  = 1'b1;
        frame_start = do_frame;
        @(negedge clk);
        line_start  = 1'b0;
        frame_start = 1'b0;
        wait_idle(busy_cyc);
        nwr = got_q.size() - wb;
        nf  = got_a_q.size() - ab;
        first_a = (nf > 0) ? got_a_q[ab] : '1;
        tmp = (nwr > 0) ? got_q[got_q.size() - 1] : '1;
        last_idx = tmp[18:8];
        score(wb, ab);
    endtask

    typedef struct {
        bit            frame;
        logic [1:0]    pw;
        logic [1:0]    ph;
        logic [AW-1:0] base;
        int            dly;
        logic [AW-1:0] exp_addr;
        int            exp_wr;
        int            exp_f;
        logic [9:0]    exp_last;
        int            exp_busy;
    } vec_t;

    vec_t vt[9];

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        int            bc, nwr, nf, ov0, wb, ab, cyc;
        logic [AW-1:0] fa;
        logic [10:0]   li;
        logic [1:0]    rpw, rph;
        logic [18:0]   tmp;
        bit            rfr;
        int            rd;

        vt[0] = '{1'b1, 2'd0, 2'd0, 15'h0000, 0, 15'h0000, 640, 160, 10'd639, 800};
        vt[1] = '{1'b0, 2'd2, 2'd0, 15'h0000, 0, 15'h00A0, 214,  54, 10'd213, 268};
        vt[2] = '{1'b1, 2'd3, 2'd2, 15'h0100, 1, 15'h0100, 160,  40, 10'd159, 240};
        vt[3] = '{1'b0, 2'd3, 2'd2, 15'h0100, 0, 15'h0100, 160,  40, 10'd159, 200};
        vt[4] = '{1'b0, 2'd3, 2'd2, 15'h0100, 2, 15'h0100, 160,  40, 10'd159, 280};
        vt[5] = '{1'b0, 2'd3, 2'd2, 15'h0100, 0, 15'h0128, 160,  40, 10'd159, 200};
        vt[6] = '{1'b0, 2'd3, 2'd2, 15'h0100, 0, 15'h0128, 160,  40, 10'd159, 200};
        vt[7] = '{1'b1, 2'd1, 2'd0, 15'h7FF0, 0, 15'h7FF0, 320,  80, 10'd319, 400};
        vt[8] = '{1'b0, 2'd1, 2'd0, 15'h7FF0, 0, 15'h0040, 320,  80, 10'd319, 400};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus", {bus_addr, bus_strobe}, 0);
        check("rst_wr", {linebuf_wr_idx, linebuf_wr_data, linebuf_wr_en}, 0);
        check("rst_flags", {linebuf_bank, busy, overrun}, 0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Table of clean lines
        ov0 = ov_cnt;
        for (int k = 0; k < 9; k++) begin
            run_line(vt[k].frame, vt[k].pw, vt[k].ph, vt[k].base, vt[k].dly, bc, fa, nwr, nf, li);
            check("tbl_first_addr", fa, vt[k].exp_addr);
            check("tbl_writes", nwr, vt[k].exp_wr);
            check("tbl_fetches", nf, vt[k].exp_f);
            check("tbl_last_pix", li[9:0], vt[k].exp_last);
            check("tbl_bank", li[10], (k % 2 == 0) ? 1 : 0);
            check("tbl_busy_cycles", bc, vt[k].exp_busy);
        end
        check("tbl_no_overrun", ov_cnt - ov0, 0);

        // Abort during FETCH with a slow ack: drained word discarded, same row refetched
        salt = 32'h5A3C_0F96;
        run_line(1'b1, 2'd3, 2'd0, 15'h0200, 3, bc, fa, nwr, nf, li);
        check("abort_pre_addr", fa, 15'h0200);
        ov0 = ov_cnt;
        wb = got_q.size();
        ab = got_a_q.size();
        exp_a_q.push_back(15'h0228);
        m_bank = ~m_bank;
        model_line(1'b0, 2'd3, 2'd0, 15'h0200);
        @(negedge clk) line_start = 1'b1;
        @(negedge clk) line_start = 1'b0;
        @(negedge clk) line_start = 1'b1;
        @(negedge clk) line_start = 1'b0;
        wait_idle(bc);
        check("abort_overrun_once", ov_cnt - ov0, 1);
        score(wb, ab);

        // frame_start together with line_start mid-frame reloads row and repeat count
        run_line(1'b1, 2'd3, 2'd1, 15'h0300, 0, bc, fa, nwr, nf, li);
        check("sim_addr0", fa, 15'h0300);
        run_line(1'b0, 2'd3, 2'd1, 15'h0300, 0, bc, fa, nwr, nf, li);
        check("sim_addr1", fa, 15'h0300);
        run_line(1'b0, 2'd3, 2'd1, 15'h0300, 0, bc, fa, nwr, nf, li);
        check("sim_addr2", fa, 15'h0328);
        run_line(1'b1, 2'd3, 2'd1, 15'h0400, 0, bc, fa, nwr, nf, li);
        check("sim_addr3", fa, 15'h0400);
        run_line(1'b0, 2'd3, 2'd1, 15'h0400, 0, bc, fa, nwr, nf, li);
        check("sim_addr4", fa, 15'h0400);

        // Reset in the middle of UNPACK
        pixel_width = 2'd0;
        ack_delay = 0;
        @(negedge clk) line_start = 1'b1;
        @(negedge clk) line_start = 1'b0;
        cyc = 0;
        while (!linebuf_wr_en && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("mid_unpack_reached", 32'(dbg_state), 32'(S_UNPACK));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_bus", {bus_addr, bus_strobe}, 0);
        check("midrst_wr", {linebuf_wr_idx, linebuf_wr_data, linebuf_wr_en}, 0);
        check("midrst_flags", {linebuf_bank, busy, overrun}, 0);
        check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
        rst = 1'b0;
        m_row = '0;
        m_rep = '0;
        m_bank = 1'b0;
        wb = got_q.size();
        run_line(1'b0, 2'd3, 2'd0, 15'h0000, 0, bc, fa, nwr, nf, li);
        tmp = (got_q.size() > wb) ? got_q[wb] : '0;
        check("post_rst_bank", tmp[18], 1);
        check("post_rst_addr", fa, 15'h0000);

        // Random lines against the model
        salt = $urandom;
        for (int k = 0; k < 8; k++) begin
            rfr = (k == 0) || ($urandom_range(0, 3) == 0);
            rpw = 2'($urandom_range(0, 3));
            rph = 2'($urandom_range(0, 3));
            rd  = $urandom_range(0, 3);
            run_line(rfr, rpw, rph, AW'($urandom_range(0, 32767)), rd, bc, fa, nwr, nf, li);
            check("rnd_busy_cycles", bc, busy_of(rpw, rd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_linebuf_fill.md
# video_linebuf_fill

Fills the double-banked 8bpp line buffer that the VGA output stage reads, one display line ahead of scan-out. On each line-start pulse the block toggles the write bank. It fetches the current source row from video RAM as 32-bit words over a strobe/ack bus and writes the unpacked palette indices into the line buffer. It handles horizontal scaling by pixel count and vertical scaling by row repetition.

## Interface
- `H_ACTIVE`, 640: output pixels per line at scale 1.
- `ADDR_W`, 15: width of the VRAM word address.
- `clk` in 1: pixel clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `pixel_width` in 2: horizontal scale minus 1 (0..3).
- `pixel_height` in 2: vertical scale minus 1 (0..3); each source row is rendered pixel_height+1 times.
- `frame_base` in ADDR_W: word address of source row 0; sampled at frame_start.
- `frame_start` in 1: single-cycle pulse, restart at row 0.
- `line_start` in 1: single-cycle pulse, begin rendering the next line.
- `bus_addr` out ADDR_W: VRAM word address.
- `bus_strobe` out 1: read request, held until ack.
- `bus_ack` in 1: `bus_rdata` valid, transfer complete.
- `bus_rdata` in 32: read word.
- `linebuf_wr_idx` out 11: bit 10 = bank, bits 9:0 = pixel index.
- `linebuf_wr_data` out 8: palette index.
- `linebuf_wr_en` out 1: write strobe.
- `linebuf_bank` out 1: bank being written; the display reads ~linebuf_bank.
- `busy` out 1: a line is being rendered.
- `overrun` out 1: one-cycle pulse, line_start or frame_start arrived while busy.

## Operation
- Source pixels per line, N: 640 for pixel_width=0, 320 for 1, 214 for 2, 160 for 3.
- Words per row, W = ceil(N/4): 160, 80, 54, 40.
- States:
  - IDLE -> FETCH on line_start.
  - FETCH: strobe asserted; on ack, capture word -> UNPACK.
  - UNPACK: emit 4 bytes, one per clock; stop early at pixel N-1.
  - UNPACK -> FETCH if pixels remain, else -> IDLE.
- Byte order is little-endian: bits 7:0 are the lowest pixel index.
- Last word for N=214: write only 2 bytes (idx 212, 213); discard bytes 2 and 3.
- Row sequencing:
  - frame_start loads row_addr=frame_base and rep_cnt=pixel_height.
  - At the end of each rendered line, if rep_cnt==0 then row_addr+=W and rep_cnt reloads pixel_height; otherwise rep_cnt decrements.
  - row_addr wraps modulo 2^ADDR_W.
- line_start toggles linebuf_bank before the first write of the line, and latches pixel_width for the whole line.
- Abort:
  - Cause: line_start or frame_start while busy.
  - Effect: pulse overrun, stop writing the current line, and skip the row-advance step for it.
  - If strobe is outstanding, hold strobe until ack, discard the data, then act on the pending event.
  - Only one event can be pending; a newer one replaces it.
- frame_start and line_start in the same cycle: frame reload applies first, then the line renders row 0 at frame_base.
- bus_addr = row_addr + word counter, held stable while strobe is high.

## Timing
- Reset values:
  - outputs: all outputs 0.
  - state: IDLE.
  - row_addr and rep_cnt: 0.
- line_start in cycle t -> bus_strobe=1 and busy=1 in t+1.
- Ack in cycle a -> first write (wr_en=1) in a+1; three further writes follow in a+2..a+4.
- The next strobe rises the cycle after the last write of the word.
- Minimum line render time with zero-wait ack: 5·W cycles, i.e. 800 cycles for pixel_width=0, which fits an 800-clock line.
- busy falls the cycle after the final write.
- wr_idx, wr_data and wr_en are registered and change together.
- Reset mid-line: immediate return to IDLE with strobe dropped; bus recovery is the bus owner's responsibility.

## Structure
- Package `video_linebuf_pkg`:
  - state enum;
  - N and W lookup functions of pixel_width;
  - linebuf index width (11) and bank bit position.
- One natural sub-module, `video_linebuf_rowgen`: frame/row address and rep_cnt sequencing, exposing row_addr and an advance strobe.
- Fetch/unpack FSM in the top level.

## Test plan
- pixel_width=0, zero-wait ack, rdata=word index·0x04040404+0x03020100:
  - 640 writes, idx 0..639 in bank 1, data = idx&0xFF;
  - 160 strobes at frame_base..+159; busy low by cycle 801.
- pixel_width=2:
  - 54 fetches, 214 writes, last idx 213;
  - bytes 2 and 3 of word 53 never written.
- pixel_height=2, pixel_width=3, frame_base=0x100, five lines: first addresses 0x100, 0x100, 0x100, 0x128, 0x128.
- line_start while in FETCH with ack delayed 3 cycles:
  - overrun pulses once; no writes from that word;
  - new line starts at the same row with the bank toggled.
- Simultaneous frame_start+line_start mid-frame: first fetch address = new frame_base; rep_cnt reloaded.
- rst asserted during UNPACK: next cycle all outputs 0, state IDLE; the following line_start writes bank 1.
